// File: rtl/queue_uart_tx.sv
// queue_uart_tx
// Sole consumer of an 8-bit, depth-4 circular queue. When transmission is
// enabled and the queue reports data, it pops one byte with a single-cycle
// dequeue pulse and captures the queue's registered output. It then sends
// that byte as an 8N1 frame, or as an 8E1 frame when PARITY_EN is set.
// Every output is driven from a flop. The flops are loaded from the
// next-state decode, so no output is combinational from an input.

module queue_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_enable,
    input  logic       q_empty,
    input  logic [7:0] q_data,
    output logic       q_dequeue,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [TW-1:0] r_bitTimer;
    logic [TW-1:0] w_nextTimer;
    logic [2:0]    r_bitIndex;
    logic [2:0]    w_nextIndex;
    logic [7:0]    r_shift;
    logic [7:0]    w_nextShift;
    logic          r_parity;
    logic          w_nextParity;
    logic          r_tx;
    logic          r_busy;
    logic          r_dequeue;
    logic          r_frameDone;
    logic          w_nextTx;
    logic          w_tickDone;

    // The current serial bit has been held for its full CLKS_PER_BIT cycles
    assign w_tickDone = (r_bitTimer == LAST_TICK);

    // Next-state, bit timer, bit index and data capture/shift decode.
    // The timer restarts from zero on every state change. The timer also
    // restarts at every data-bit boundary inside DATA.
    always_comb begin
        w_nextState  = r_state;
        w_nextTimer  = r_bitTimer + 1'b1;
        w_nextIndex  = r_bitIndex;
        w_nextShift  = r_shift;
        w_nextParity = r_parity;

        case (r_state)
            IDLE: begin
                w_nextTimer = '0;
                if (tx_enable && !q_empty) begin
                    w_nextState = POP;
                end
            end

            POP: begin
                // The queue is not re-checked here; the pop is already committed
                w_nextTimer = '0;
                w_nextState = LOAD;
            end

            LOAD: begin
                // The queue's registered output is valid during this cycle
                w_nextTimer  = '0;
                w_nextIndex  = '0;
                w_nextShift  = q_data;
                w_nextParity = ^q_data;
                w_nextState  = START;
            end

            START: begin
                if (w_tickDone) begin
                    w_nextTimer = '0;
                    w_nextIndex = '0;
                    w_nextState = DATA;
                end
            end

            DATA: begin
                if (w_tickDone) begin
                    w_nextTimer = '0;
                    w_nextShift = {1'b0, r_shift[7:1]};
                    if (r_bitIndex == 3'd7) begin
                        w_nextIndex = '0;
                        w_nextState = PARITY_EN ? PARITY : STOP;
                    end else begin
                        w_nextIndex = r_bitIndex + 1'b1;
                    end
                end
            end

            PARITY: begin
                if (w_tickDone) begin
                    w_nextTimer = '0;
                    w_nextState = STOP;
                end
            end

            STOP: begin
                if (w_tickDone) begin
                    w_nextTimer = '0;
                    w_nextState = IDLE;
                end
            end

            default: begin
                w_nextTimer = '0;
                w_nextState = IDLE;
            end
        endcase
    end

    // Line level for the cycle after the coming edge, taken from the next state.
    // The tx flop therefore changes together with the state register.
    always_comb begin
        w_nextTx = 1'b1;
        case (w_nextState)
            START:   w_nextTx = 1'b0;
            DATA:    w_nextTx = w_nextShift[0];
            PARITY:  w_nextTx = w_nextParity;
            default: w_nextTx = 1'b1;
        endcase
    end

    // State, datapath and registered outputs. Reset abandons any frame in
    // flight, and the byte it was carrying is not fetched again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bitTimer  <= '0;
            r_bitIndex  <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_dequeue   <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_bitTimer  <= w_nextTimer;
            r_bitIndex  <= w_nextIndex;
            r_shift     <= w_nextShift;
            r_parity    <= w_nextParity;
            r_tx        <= w_nextTx;
            r_busy      <= (w_nextState != IDLE);
            r_dequeue   <= (w_nextState == POP);
            r_frameDone <= (r_state == STOP) && (w_nextState == IDLE);
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign q_dequeue  = r_dequeue;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_queue_uart_tx.sv
// tb_queue_uart_tx
// Two transmitters share reset and enable: one is 8N1 and one is 8E1, both at
// 4 clocks per bit. Each one has its own depth-4 queue model. A per-cycle
// reference model expands every pop into the expected cycle-by-cycle outputs
// for the whole frame. A simple UART receiver decodes the line so that
// received bytes can be checked against fixed tables.

module tb_queue_uart_tx;

    localparam int CPB = 4;
    localparam int NV  = 8;

    typedef struct packed {
        logic tx;
        logic busy;
        logic dq;
        logic fd;
        logic isIdle;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       expParity;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       txEnable;
    logic       qEmpty    [2];
    logic [7:0] qData     [2];
    logic       qDequeue  [2];
    logic       tx        [2];
    logic       busy      [2];
    logic       frameDone [2];

    int nCompared   = 0;
    int nMismatched = 0;
    int cycle       = 0;

    exp_t       pend0 [$];
    exp_t       pend1 [$];
    logic [7:0] fifo0 [$];
    logic [7:0] fifo1 [$];

    logic        modelIdle [2];
    logic        prevTx    [2];
    logic        rxActive  [2];
    int          rxCnt     [2];
    logic [10:0] rxBits    [2];
    logic        rxParity  [2];
    logic [7:0]  rxHist    [2][256];
    int          rxFrames  [2];
    int          dqCount   [2];
    int          doneCount [2];
    int          lastDq    [2];
    int          lastStart [2];
    int          lastDone  [2];

    vec_t       vecs [NV];
    logic [7:0] b2b  [4];

    queue_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (txEnable),
        .q_empty    (qEmpty[0]),
        .q_data     (qData[0]),
        .q_dequeue  (qDequeue[0]),
        .tx         (tx[0]),
        .busy       (busy[0]),
        .frame_done (frameDone[0])
    );

    queue_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (txEnable),
        .q_empty    (qEmpty[1]),
        .q_data     (qData[1]),
        .q_dequeue  (qDequeue[1]),
        .tx         (tx[1]),
        .busy       (busy[1]),
        .frame_done (frameDone[1])
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t mkExp(input logic t, input logic b, input logic d,
                                   input logic f, input logic i);
        exp_t e;
        e = {t, b, d, f, i};
        return e;
    endfunction

    function automatic int pendSize(input logic k);
        return k ? pend1.size() : pend0.size();
    endfunction

    function automatic int fifoSize(input logic k);
        return k ? fifo1.size() : fifo0.size();
    endfunction

    task automatic compareBit(input string name, input int k, input logic act, input logic expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %b, required %b", name, k, cycle, act, expv);
        end
    endtask

    task automatic compareVal(input string name, input int k, input logic [31:0] act,
                              input logic [31:0] expv);
        nCompared++;
        if (act !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h, required %0h", name, k, cycle, act, expv);
        end
    endtask

    task automatic pushPend(input logic k, input exp_t e);
        if (k) pend1.push_back(e);
        else   pend0.push_back(e);
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifo0.push_back(b);
        fifo1.push_back(b);
        qEmpty[0] = 1'b0;
        qEmpty[1] = 1'b0;
    endtask

    // Reference model: an idle transmitter that sees enable and data at the
    // edge pops once. The pop costs two set-up cycles (pop, load), then the
    // frame bits follow, each held CPB cycles, and then the done cycle.
    task automatic modelDecide(input logic k);
        logic [7:0] b;
        logic       level;
        int         nb;
        if (reset) begin
            if (k) pend1.delete();
            else   pend0.delete();
            modelIdle[k] = 1'b1;
            rxActive[k]  = 1'b0;
            return;
        end
        if (modelIdle[k] && txEnable && !qEmpty[k]) begin
            b  = k ? fifo1[0] : fifo0[0];
            nb = k ? 11 : 10;
            pushPend(k, mkExp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
            pushPend(k, mkExp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
            for (int j = 0; j < nb; j++) begin
                if (j == 0)            level = 1'b0;
                else if (j <= 8)       level = b[j-1];
                else if (j == nb - 1)  level = 1'b1;
                else                   level = ^b;
                for (int c = 0; c < CPB; c++) begin
                    pushPend(k, mkExp(level, 1'b1, 1'b0, 1'b0, 1'b0));
                end
            end
            pushPend(k, mkExp(1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
            modelIdle[k] = 1'b0;
        end
    endtask

    // Compare one cycle of outputs, run the line receiver, serve the queue
    task automatic checkOutput(input logic k);
        exp_t       e;
        int         idx;
        int         nb;
        logic [7:0] d;
        nb = k ? 11 : 10;
        if (pendSize(k) == 0) e = mkExp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        else if (k)           e = pend1.pop_front();
        else                  e = pend0.pop_front();

        compareBit("tx", int'(k), tx[k], e.tx);
        compareBit("busy", int'(k), busy[k], e.busy);
        compareBit("q_dequeue", int'(k), qDequeue[k], e.dq);
        compareBit("frame_done", int'(k), frameDone[k], e.fd);
        modelIdle[k] = e.isIdle;

        if (qDequeue[k] === 1'b1) begin
            dqCount[k]++;
            lastDq[k] = cycle;
        end
        if (frameDone[k] === 1'b1) begin
            doneCount[k]++;
            lastDone[k] = cycle;
        end

        if (rxActive[k]) begin
            rxCnt[k]++;
        end else if (prevTx[k] === 1'b1 && tx[k] === 1'b0) begin
            rxActive[k]  = 1'b1;
            rxCnt[k]     = 0;
            lastStart[k] = cycle;
        end
        if (rxActive[k] && (rxCnt[k] % CPB) == CPB / 2) begin
            idx = rxCnt[k] / CPB;
            rxBits[k][4'(idx)] = tx[k];
            if (idx == nb - 1) begin
                d = rxBits[k][8:1];
                compareBit("start_bit", int'(k), rxBits[k][0], 1'b0);
                compareBit("stop_bit", int'(k), rxBits[k][4'(nb - 1)], 1'b1);
                if (k) begin
                    rxParity[k] = rxBits[k][9];
                    compareBit("even_parity", int'(k), rxBits[k][9], ^d);
                end
                rxHist[k][8'(rxFrames[k] % 256)] = d;
                rxFrames[k]++;
                rxActive[k] = 1'b0;
            end
        end
        prevTx[k] = tx[k];

        if (qDequeue[k] === 1'b1) begin
            compareBit("pop_nonempty", int'(k), fifoSize(k) > 0, 1'b1);
            if (fifoSize(k) > 0) begin
                qData[k] = k ? fifo1.pop_front() : fifo0.pop_front();
            end
            qEmpty[k] = (fifoSize(k) == 0);
        end
    endtask

    // One clock cycle: predict from the inputs that the edge samples, then check
    task automatic applyStimulus();
        modelDecide(1'b0);
        modelDecide(1'b1);
        @(negedge clk);
        cycle++;
        checkOutput(1'b0);
        checkOutput(1'b1);
    endtask

    function automatic logic allIdle();
        logic r;
        r = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (pendSize(1'(k)) != 0 || !modelIdle[k] || (txEnable && !qEmpty[k])) r = 1'b0;
        end
        return r;
    endfunction

    task automatic runUntilIdle(input int maxCycles);
        int n;
        n = 0;
        while (!allIdle()) begin
            if (n >= maxCycles) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL drain_timeout cycle %0d: got still busy after %0d cycles, required idle", cycle, n);
                return;
            end
            applyStimulus();
            n++;
        end
    endtask

    initial begin
        int         dqBase [2];
        int         frBase [2];
        int         n;
        logic [7:0] b;
        logic [7:0] pushed [$];

        vecs[0] = {8'hA5, 1'b0};
        vecs[1] = {8'h01, 1'b1};
        vecs[2] = {8'hFF, 1'b0};
        vecs[3] = {8'h00, 1'b0};
        vecs[4] = {8'h80, 1'b1};
        vecs[5] = {8'h3C, 1'b0};
        vecs[6] = {8'h5B, 1'b1};
        vecs[7] = {8'h7E, 1'b0};
        b2b[0] = 8'h11;
        b2b[1] = 8'h22;
        b2b[2] = 8'h33;
        b2b[3] = 8'h44;

        reset    = 1'b1;
        txEnable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            qEmpty[k]    = 1'b1;
            qData[k]     = 8'h00;
            modelIdle[k] = 1'b1;
            prevTx[k]    = 1'b1;
            rxActive[k]  = 1'b0;
            rxCnt[k]     = 0;
            rxBits[k]    = '0;
            rxParity[k]  = 1'b0;
            rxFrames[k]  = 0;
            dqCount[k]   = 0;
            doneCount[k] = 0;
            lastDq[k]    = 0;
            lastStart[k] = 0;
            lastDone[k]  = 0;
        end

        // Reset held three cycles, then an empty queue for fifty cycles
        repeat (3) applyStimulus();
        reset = 1'b0;
        repeat (50) applyStimulus();
        compareVal("idle_no_pop", 0, dqCount[0], 0);
        compareVal("idle_no_pop", 1, dqCount[1], 0);

        // Table of single-byte frames: decoded data, parity, latency, length
        txEnable = 1'b1;
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < 2; k++) frBase[k] = rxFrames[k];
            pushByte(vecs[i].data);
            runUntilIdle(200);
            for (int k = 0; k < 2; k++) begin
                compareVal("rx_frames", k, rxFrames[k], frBase[k] + 1);
                compareVal("rx_data", k, 32'(rxHist[k][8'((rxFrames[k] + 255) % 256)]), 32'(vecs[i].data));
                compareVal("pop_to_start", k, lastStart[k] - lastDq[k], 2);
                compareVal("frame_len", k, lastDone[k] - lastStart[k], (k == 1) ? 11 * CPB : 10 * CPB);
            end
            compareBit("rx_parity", 1, rxParity[1], vecs[i].expParity);
        end

        // Fill the queue while disabled, then drain four frames back to back
        txEnable = 1'b0;
        for (int j = 0; j < 4; j++) pushByte(b2b[j]);
        for (int k = 0; k < 2; k++) begin
            dqBase[k] = dqCount[k];
            frBase[k] = rxFrames[k];
        end
        repeat (10) applyStimulus();
        compareVal("disabled_no_pop", 0, dqCount[0], dqBase[0]);
        txEnable = 1'b1;
        runUntilIdle(800);
        for (int k = 0; k < 2; k++) begin
            compareVal("b2b_pops", k, dqCount[k] - dqBase[k], 4);
            compareVal("b2b_frames", k, rxFrames[k] - frBase[k], 4);
            for (int j = 0; j < 4; j++) begin
                compareVal("b2b_order", k, 32'(rxHist[k][8'((frBase[k] + j) % 256)]), 32'(b2b[j]));
            end
        end

        // Enable gating: no pop while disabled, and dropping enable mid-frame
        // lets the frame finish but prevents the next pop
        txEnable = 1'b0;
        pushByte(8'h66);
        pushByte(8'h77);
        for (int k = 0; k < 2; k++) dqBase[k] = dqCount[k];
        repeat (30) applyStimulus();
        compareVal("enable_low_no_pop", 0, dqCount[0] - dqBase[0], 0);
        compareVal("enable_low_no_pop", 1, dqCount[1] - dqBase[1], 0);
        txEnable = 1'b1;
        repeat (15) applyStimulus();
        txEnable = 1'b0;
        runUntilIdle(200);
        repeat (40) applyStimulus();
        for (int k = 0; k < 2; k++) begin
            compareVal("enable_drop_pops", k, dqCount[k] - dqBase[k], 1);
            compareVal("enable_drop_left", k, fifoSize(1'(k)), 1);
            compareVal("enable_drop_data", k, 32'(rxHist[k][8'((rxFrames[k] + 255) % 256)]), 32'h66);
        end
        txEnable = 1'b1;
        runUntilIdle(200);
        compareVal("enable_resume_data", 0, 32'(rxHist[0][8'((rxFrames[0] + 255) % 256)]), 32'h77);
        compareVal("enable_resume_data", 1, 32'(rxHist[1][8'((rxFrames[1] + 255) % 256)]), 32'h77);

        // Reset during data bit 3 of 0x5A with two bytes still queued
        for (int k = 0; k < 2; k++) begin
            dqBase[k] = dqCount[k];
            frBase[k] = rxFrames[k];
        end
        pushByte(8'h5A);
        pushByte(8'h11);
        pushByte(8'h22);
        n = 0;
        while (!rxActive[0] && n < 20) begin
            applyStimulus();
            n++;
        end
        compareBit("start_seen", 0, rxActive[0], 1'b1);
        repeat (4 * CPB) applyStimulus();
        compareBit("data_bit3", 0, tx[0], 1'b1);
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            compareBit("tx_after_reset", k, tx[k], 1'b1);
            compareBit("busy_after_reset", k, busy[k], 1'b0);
        end
        runUntilIdle(400);
        for (int k = 0; k < 2; k++) begin
            compareVal("reset_pops", k, dqCount[k] - dqBase[k], 3);
            compareVal("reset_frames", k, rxFrames[k] - frBase[k], 2);
            compareVal("reset_next_a", k, 32'(rxHist[k][8'(frBase[k] % 256)]), 32'h11);
            compareVal("reset_next_b", k, 32'(rxHist[k][8'((frBase[k] + 1) % 256)]), 32'h22);
        end

        // Random pushes and enable toggling, checked cycle by cycle by the model
        for (int k = 0; k < 2; k++) frBase[k] = rxFrames[k];
        txEnable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0 && fifoSize(1'b0) < 4 && fifoSize(1'b1) < 4) begin
                b = 8'($urandom);
                pushByte(b);
                pushed.push_back(b);
            end
            if ($urandom_range(0, 40) == 0) txEnable = ~txEnable;
            applyStimulus();
        end
        txEnable = 1'b1;
        runUntilIdle(3000);
        for (int k = 0; k < 2; k++) begin
            compareVal("rand_frames", k, rxFrames[k] - frBase[k], pushed.size());
            for (int j = 0; j < pushed.size(); j++) begin
                compareVal("rand_data", k, 32'(rxHist[k][8'((frBase[k] + j) % 256)]), 32'(pushed[j]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
